// File: rtl/mn_flow_queue_pkg.sv
// Shared sizing helpers and D-to-RrAg field definitions for the M/N flow queue.
package mn_queue_pkg;

   localparam int unsigned D_RRAG_M_WIDTH = 8;
   localparam int unsigned D_RRAG_N_WIDTH = 8;

   typedef struct packed {
      logic [D_RRAG_M_WIDTH-1:0] m;
      logic [D_RRAG_N_WIDTH-1:0] n;
   } d_rrag_entry_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return int'($clog2(depth));
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return int'($clog2(depth)) + 1;
   endfunction

   // Low bit of slice idx in a flat vector of width-bit slices.
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

   function automatic d_rrag_entry_t d_rrag_pack(input logic [D_RRAG_M_WIDTH-1:0] m,
                                                 input logic [D_RRAG_N_WIDTH-1:0] n);
      d_rrag_entry_t e;
      e.m = m;
      e.n = n;
      return e;
   endfunction

endpackage

// File: rtl/mn_flow_queue_if.sv
// Handshake/data bundle for mn_flow_queue; master drives requests, slave is the queue.
interface mn_flow_queue_if
   import mn_queue_pkg::*;
#(
   parameter int unsigned M_WIDTH = 8,
   parameter int unsigned N_WIDTH = 8,
   parameter int unsigned DEPTH   = 8
);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic                       flush;
   logic                       wr;
   logic [M_WIDTH-1:0]         m_din;
   logic [N_WIDTH-1:0]         n_din;
   logic                       rd;
   logic [DEPTH-1:0]           modify_vector;
   logic [M_WIDTH*DEPTH-1:0]   new_m_vector;
   logic [M_WIDTH*DEPTH-1:0]   old_m_vector;
   logic [M_WIDTH+N_WIDTH-1:0] dout;
   logic                       dout_valid;
   logic                       full;
   logic                       empty;
   logic                       almost_full;
   logic [CNT_W-1:0]           count;

   modport master (
      output flush, wr, m_din, n_din, rd, modify_vector, new_m_vector,
      input  old_m_vector, dout, dout_valid, full, empty, almost_full, count
   );

   modport slave (
      input  flush, wr, m_din, n_din, rd, modify_vector, new_m_vector,
      output old_m_vector, dout, dout_valid, full, empty, almost_full, count
   );
endinterface

// File: rtl/mn_flow_queue_ptr.sv
// Head/tail/occupancy tracking for mn_flow_queue, including accept decisions.
// MN_QUEUE_BYPASS_EN: empty-queue wr+rd passes through without being stored.
module mn_queue_ptr
   import mn_queue_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   localparam int unsigned PTR_W    = ptr_w(DEPTH),
   localparam int unsigned CNT_W    = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             flush,
   input  logic             wr,
   input  logic             rd,
   output logic [PTR_W-1:0] head,
   output logic [PTR_W-1:0] tail,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             wr_acc,
   output logic             rd_acc
);

   logic bypass_take;

   always_comb begin
      empty       = (count == '0);
      full        = (count == CNT_W'(DEPTH));
      almost_full = (32'(count) >= AF_THRESH);
`ifdef MN_QUEUE_BYPASS_EN
      bypass_take = empty & wr & rd;
`else
      bypass_take = 1'b0;
`endif
      wr_acc = wr & ~flush & (~full | rd) & ~bypass_take;
      rd_acc = rd & ~flush & ~empty;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) tail <= tail + 1'b1;
         if (rd_acc) head <= head + 1'b1;
         count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      end
   end

endmodule

// File: rtl/mn_flow_queue.sv
// Circular M/N queue with head-relative modify/observe of the M field.
// MN_QUEUE_BYPASS_EN: combinational pass-through of {m_din,n_din} while empty.
module mn_flow_queue
   import mn_queue_pkg::*;
#(
   parameter int unsigned M_WIDTH   = 8,
   parameter int unsigned N_WIDTH   = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 2
) (
   input logic          clk,
   input logic          clr,
   mn_flow_queue_if.slave q
);
   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned CNT_W = cnt_w(DEPTH);

   logic [M_WIDTH-1:0] m_mem [DEPTH];
   logic [N_WIDTH-1:0] n_mem [DEPTH];
   logic [PTR_W-1:0]   head, tail;
   logic [CNT_W-1:0]   count;
   logic               full, empty, almost_full, wr_acc, rd_acc;
   logic [PTR_W-1:0]   phys [DEPTH];
   logic [DEPTH-1:0]   occupied;
   logic [DEPTH-1:0]   mod_en;

   mn_queue_ptr #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH)
   ) u_ptr (
      .clk         (clk),
      .clr         (clr),
      .flush       (q.flush),
      .wr          (q.wr),
      .rd          (q.rd),
      .head        (head),
      .tail        (tail),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .wr_acc      (wr_acc),
      .rd_acc      (rd_acc)
   );

   // A head being dequeued this cycle leaves unmodified.
   always_comb begin
      q.old_m_vector = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         phys[i]     = head + PTR_W'(i);
         occupied[i] = (CNT_W'(i) < count);
         mod_en[i]   = q.modify_vector[i] & occupied[i] & ~q.flush & ~((i == 0) && rd_acc);
         q.old_m_vector[slice_lo(i, M_WIDTH) +: M_WIDTH] = occupied[i] ? m_mem[phys[i]] : '0;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            m_mem[j] <= '0;
            n_mem[j] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mod_en[i]) m_mem[phys[i]] <= q.new_m_vector[slice_lo(i, M_WIDTH) +: M_WIDTH];
         end
         if (wr_acc) begin
            m_mem[tail] <= q.m_din;
            n_mem[tail] <= q.n_din;
         end
      end
   end

   always_comb begin
      q.count       = count;
      q.full        = full;
      q.empty       = empty;
      q.almost_full = almost_full;
      q.dout        = '0;
      q.dout_valid  = 1'b0;
      if (!empty) begin
         q.dout       = {m_mem[head], n_mem[head]};
         q.dout_valid = 1'b1;
      end
`ifdef MN_QUEUE_BYPASS_EN
      else if (q.wr && !q.flush) begin
         q.dout       = {q.m_din, q.n_din};
         q.dout_valid = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_mn_flow_queue.sv
// Directed bench for mn_flow_queue (DEPTH=8, 8-bit M/N); honours MN_QUEUE_BYPASS_EN.
module tb_mn_flow_queue;

   logic clk;
   logic clr;
   int   n_cmp = 0;
   int   n_bad = 0;

   mn_flow_queue_if #(.M_WIDTH(8), .N_WIDTH(8), .DEPTH(8)) q ();

   mn_flow_queue #(
      .M_WIDTH   (8),
      .N_WIDTH   (8),
      .DEPTH     (8),
      .AF_THRESH (6)
   ) dut (
      .clk (clk),
      .clr (clr),
      .q   (q.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [7:0]  m;
      logic [7:0]  n;
      int          exp_cnt;
      logic [15:0] exp_dout;
   } vec_t;

   vec_t vt [23];

   function automatic vec_t mk(input logic w, input logic r, input logic [7:0] m, input logic [7:0] n,
                               input int cnt, input logic [15:0] d);
      vec_t v;
      v.wr = w; v.rd = r; v.m = m; v.n = n; v.exp_cnt = cnt; v.exp_dout = d;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_in(input logic f, input logic w, input logic r, input logic [7:0] m,
                         input logic [7:0] n, input logic [7:0] mv, input logic [63:0] nm);
      q.flush = f; q.wr = w; q.rd = r; q.m_din = m; q.n_din = n;
      q.modify_vector = mv; q.new_m_vector = nm;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 64'h0);
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic [15:0] d, input logic dv);
      chk({tag, ".count"}, 64'(q.count), 64'(cnt));
      chk({tag, ".empty"}, 64'(q.empty), 64'(cnt == 0));
      chk({tag, ".full"}, 64'(q.full), 64'(cnt == 8));
      chk({tag, ".almost_full"}, 64'(q.almost_full), 64'(cnt >= 6));
      chk({tag, ".dout"}, 64'(q.dout), 64'(d));
      chk({tag, ".dout_valid"}, 64'(q.dout_valid), 64'(dv));
   endtask

   initial begin
      logic [15:0] ed;
      logic        ev;

      idle();
      clr = 1'b1;
      #12;
      chk_state("reset", 0, 16'h0000, 1'b0);
      chk("reset.old_m", q.old_m_vector, 64'h0);
      @(negedge clk);
      clr = 1'b0;

      // Fill to full, overflow drop, wr+rd while full, then drain across the wrap.
      vt[0] = mk(0, 0, 8'h00, 8'h00, 0, 16'h0000);
      for (int k = 0; k < 8; k++)
         vt[1+k] = mk(1, 0, 8'(k), 8'(8'h10 + k), k, (k == 0) ? 16'h0000 : 16'h0010);
      vt[9]  = mk(1, 0, 8'h99, 8'h99, 8, 16'h0010);
      vt[10] = mk(0, 0, 8'h00, 8'h00, 8, 16'h0010);
      vt[11] = mk(1, 1, 8'hAA, 8'hBB, 8, 16'h0010);
      for (int k = 0; k < 7; k++)
         vt[12+k] = mk(0, 1, 8'h00, 8'h00, 8 - k, {8'(k + 1), 8'(8'h11 + k)});
      vt[19] = mk(0, 1, 8'h00, 8'h00, 1, 16'hAABB);
      vt[20] = mk(0, 0, 8'h00, 8'h00, 0, 16'h0000);
      vt[21] = mk(0, 1, 8'h00, 8'h00, 0, 16'h0000);
      vt[22] = mk(0, 0, 8'h00, 8'h00, 0, 16'h0000);

      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         set_in(1'b0, vt[i].wr, vt[i].rd, vt[i].m, vt[i].n, 8'h00, 64'h0);
         #1;
         ed = vt[i].exp_dout;
         ev = (vt[i].exp_cnt != 0);
`ifdef MN_QUEUE_BYPASS_EN
         if (vt[i].exp_cnt == 0 && vt[i].wr) begin
            ed = {vt[i].m, vt[i].n};
            ev = 1'b1;
         end
`endif
         chk_state($sformatf("vec%0d", i), vt[i].exp_cnt, ed, ev);
      end

      // Modify logical entries 0 and 2; bit 7 points past the occupancy.
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         set_in(1'b0, 1'b1, 1'b0, 8'(k), 8'(8'h1F + k), 8'h00, 64'h0);
      end
      @(negedge clk);
      idle();
      #1;
      chk("mod.pre_count", 64'(q.count), 64'd3);
      chk("mod.pre_old_m", q.old_m_vector, 64'h0000_0000_0003_0201);
      set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h85, 64'h7700_0000_0033_2211);
      @(negedge clk);
      idle();
      #1;
      chk("mod.old_m", q.old_m_vector, 64'h0000_0000_0033_0211);
      chk("mod.count", 64'(q.count), 64'd3);

      // Head modify racing a dequeue.
      set_in(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 64'h55);
      #1;
      chk("hmod.dout", 64'(q.dout), 64'h1120);
      @(negedge clk);
      idle();
      #1;
      chk("hmod.count", 64'(q.count), 64'd2);
      chk("hmod.dout_next", 64'(q.dout), 64'h0221);
      chk("hmod.old_m", q.old_m_vector, 64'h0000_0000_0000_3302);

      // Flush beats wr, rd and modify.
      for (int k = 4; k <= 6; k++) begin
         @(negedge clk);
         set_in(1'b0, 1'b1, 1'b0, 8'(k), 8'(8'h1F + k), 8'h00, 64'h0);
      end
      @(negedge clk);
      idle();
      #1;
      chk("flush.pre_count", 64'(q.count), 64'd5);
      set_in(1'b1, 1'b1, 1'b1, 8'hEE, 8'hEE, 8'hFF, {8{8'h99}});
      @(negedge clk);
      idle();
      #1;
      chk_state("flush", 0, 16'h0000, 1'b0);
      chk("flush.old_m", q.old_m_vector, 64'h0);
      set_in(1'b0, 1'b1, 1'b0, 8'h07, 8'h26, 8'h00, 64'h0);
      @(negedge clk);
      idle();
      #1;
      chk_state("post_flush", 1, 16'h0726, 1'b1);
      chk("post_flush.old_m", q.old_m_vector, 64'h07);

      // Asynchronous clear in the middle of a write burst.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_in(1'b0, 1'b1, 1'b0, 8'(8'h40 + k), 8'(8'h50 + k), 8'h00, 64'h0);
      end
      @(negedge clk);
      idle();
      #1;
      chk("burst.count", 64'(q.count), 64'd4);
      #1;
      clr = 1'b1;
      #1;
      chk_state("clr_mid", 0, 16'h0000, 1'b0);
      chk("clr_mid.old_m", q.old_m_vector, 64'h0);
      @(negedge clk);
      clr = 1'b0;

      // wr+rd on an empty queue.
      @(negedge clk);
      set_in(1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3, 8'h00, 64'h0);
      #1;
`ifdef MN_QUEUE_BYPASS_EN
      chk_state("bypass", 0, 16'h5AC3, 1'b1);
`else
      chk_state("bypass", 0, 16'h0000, 1'b0);
`endif
      @(negedge clk);
      idle();
      #1;
`ifdef MN_QUEUE_BYPASS_EN
      chk_state("bypass_next", 0, 16'h0000, 1'b0);
`else
      chk_state("bypass_next", 1, 16'h5AC3, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
